// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: FSM encoding, grant width and SRAM geometry shared by the arbiter and ram_ctrl.
package sram_arbiter_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_BUSY   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;
   localparam int SRAM_ADDR_W = 20;
   localparam int SRAM_DATA_W = 32;
   localparam int GRANT_W     = 3;
   // Distance of port p after last in round-robin order: 1 is next in line, n is last itself
   function automatic int rr_dist(input int p, input int last, input int n);
      return (p > last) ? p - last : p - last + n;
   endfunction
endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder; first requester after i_last wins.
module rr_pick
   import sram_arbiter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]       i_req,
   input  logic [GRANT_W-1:0] i_last,
   output logic [GRANT_W-1:0] o_idx,
   output logic               o_any
);
   int w_best;
   always_comb begin
      o_idx  = '0;
      o_any  = 1'b0;
      w_best = N + 1;
      for (int p = 0; p < N; p++) begin
         if (i_req[p] && rr_dist(p, int'(i_last), N) < w_best) begin
            w_best = rr_dist(p, int'(i_last), N);
            o_idx  = GRANT_W'(p);
            o_any  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: N-port round-robin front end serialising clients onto the single-requester SRAM controller.
// Define SRAM_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYC cycles with rsp_err and a sticky timeout_flag.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int NUM_PORTS   = 4,
   parameter int ADDR_W      = SRAM_ADDR_W,
   parameter int DATA_W      = SRAM_DATA_W,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [NUM_PORTS-1:0]        i_req_valid,
   input  logic [NUM_PORTS-1:0]        i_req_we,
   input  logic [NUM_PORTS*ADDR_W-1:0] i_req_addr,
   input  logic [NUM_PORTS*DATA_W-1:0] i_req_wdata,
   output logic [NUM_PORTS-1:0]        o_req_ready,
   output logic [NUM_PORTS-1:0]        o_rsp_valid,
   output logic [DATA_W-1:0]           o_rsp_rdata,
   output logic                        o_rsp_err,
   output logic                        o_mem_read,
   output logic                        o_mem_write,
   output logic [ADDR_W-1:0]           o_mem_addr,
   output logic [DATA_W-1:0]           o_mem_wdata,
   input  logic                        i_mem_done,
   input  logic [DATA_W-1:0]           i_mem_rdata,
   output logic                        o_busy,
   output logic [GRANT_W-1:0]          o_grant_idx,
   output logic                        o_timeout_flag
);
   state_t                r_state, w_next;
   logic [GRANT_W-1:0]    r_g, r_last, w_pick;
   logic                  w_any, r_we, w_to, w_err;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_wdata, r_rdata;
   logic [ADDR_W-1:0]     w_addr  [2**GRANT_W];
   logic [DATA_W-1:0]     w_wdata [2**GRANT_W];
   logic [2**GRANT_W-1:0] w_we;
   logic [NUM_PORTS-1:0]  w_oh;

   if (NUM_PORTS < 2 || NUM_PORTS > 2**GRANT_W || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 2047) begin : g_bad_cfg
      $error("sram_arbiter: unsupported NUM_PORTS or TIMEOUT_CYC");
   end

   rr_pick #(.N(NUM_PORTS)) u_pick (
      .i_req  (i_req_valid),
      .i_last (r_last),
      .o_idx  (w_pick),
      .o_any  (w_any)
   );

   // Unpack to a full 2**GRANT_W table so the 3-bit grant indexes it exactly
   for (genvar p = 0; p < 2**GRANT_W; p++) begin : g_port
      if (p < NUM_PORTS) begin : g_on
         assign w_addr[p]  = i_req_addr[p*ADDR_W +: ADDR_W];
         assign w_wdata[p] = i_req_wdata[p*DATA_W +: DATA_W];
         assign w_we[p]    = i_req_we[p];
      end else begin : g_off
         assign w_addr[p]  = '0;
         assign w_wdata[p] = '0;
         assign w_we[p]    = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      case (r_state)
         ST_IDLE:   w_next = w_any ? ST_ACCEPT : ST_IDLE;
         ST_ACCEPT: w_next = ST_BUSY;
         ST_BUSY:   w_next = (i_mem_done || w_to) ? ST_RESP : ST_BUSY;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_g     <= '0;
         r_last  <= GRANT_W'(NUM_PORTS - 1);
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         if (r_state == ST_IDLE && w_any) begin
            r_g     <= w_pick;
            r_we    <= w_we[w_pick];
            r_addr  <= w_addr[w_pick];
            r_wdata <= w_wdata[w_pick];
         end
         // Writes and timeout aborts hand back zero data
         if (r_state == ST_BUSY && (i_mem_done || w_to)) r_rdata <= (r_we || !i_mem_done) ? '0 : i_mem_rdata;
         if (r_state == ST_RESP) r_last <= r_g;
      end
   end

   assign w_oh = NUM_PORTS'(1) << r_g;

   always_comb begin
      o_req_ready = (r_state == ST_ACCEPT) ? w_oh : '0;
      o_rsp_valid = (r_state == ST_RESP) ? w_oh : '0;
      o_rsp_rdata = (r_state == ST_RESP) ? r_rdata : '0;
      o_rsp_err   = (r_state == ST_RESP) && w_err;
      o_mem_read  = (r_state == ST_BUSY) && !r_we;
      o_mem_write = (r_state == ST_BUSY) && r_we;
      o_busy      = r_state != ST_IDLE;
   end

   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;
   assign o_grant_idx = r_g;

`ifdef SRAM_ARB_TIMEOUT_EN
   logic [10:0] r_cnt;
   logic        r_err, r_tflag;
   assign w_to           = (r_state == ST_BUSY) && !i_mem_done && (r_cnt == 11'(TIMEOUT_CYC - 1));
   assign w_err          = r_err;
   assign o_timeout_flag = r_tflag;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_tflag <= 1'b0;
      end else begin
         r_cnt <= (r_state == ST_BUSY) ? r_cnt + 11'd1 : '0;
         if (r_state == ST_BUSY && (i_mem_done || w_to)) r_err <= w_to;
         if (w_to) r_tflag <= 1'b1;
      end
   end
`else
   assign w_to           = 1'b0;
   assign w_err          = 1'b0;
   assign o_timeout_flag = 1'b0;
`endif
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Parametrised N-port round-robin arbiter in front of the single-requester SRAM controller (read/write/workdone handshake). Replaces the current point-to-point hookup between one client and ram_ctrl.
- Lets the camera, VGA and UART paths, plus test logic, share the 20-bit × 32-bit SRAM.
- Serialises accesses, returns read data to the owning port, and reports per-port completion.

Parameters:
- NUM_PORTS, 4, number of requesting clients (2..8)
- ADDR_W, 20, SRAM word-address width
- DATA_W, 32, SRAM data width
- TIMEOUT_CYC, 1023, BUSY-state cycle limit (used only with the optional feature)

Ports:
- clk  in  1  system clock (qu_clk domain)
- rst  in  1  asynchronous active-low reset
- req_valid  in  NUM_PORTS  per-port request pending; level, held until accepted
- req_we  in  NUM_PORTS  per-port 1=write, 0=read
- req_addr  in  NUM_PORTS*ADDR_W  flattened; port i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_PORTS*DATA_W  flattened, same packing
- req_ready  out  NUM_PORTS  one-cycle accept pulse to the granted port
- rsp_valid  out  NUM_PORTS  one-cycle completion pulse to the owning port
- rsp_rdata  out  DATA_W  read data, shared; valid while rsp_valid is high
- rsp_err  out  1  completion was a timeout abort
- mem_read  out  1  to ram_ctrl.read
- mem_write  out  1  to ram_ctrl.write
- mem_addr  out  ADDR_W  to ram_ctrl.inp_addr
- mem_wdata  out  DATA_W  to ram_ctrl.inp_data
- mem_done  in  1  from ram_ctrl.workdone
- mem_rdata  in  DATA_W  from ram_ctrl.out_data
- busy  out  1  high in any state other than IDLE
- grant_idx  out  3  index of the current or last granted port
- timeout_flag  out  1  sticky; set on any timeout abort

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; last_grant=NUM_PORTS-1, so port 0 wins first. All outputs are 0: req_ready, rsp_valid, rsp_rdata, rsp_err, mem_read, mem_write, mem_addr, mem_wdata, busy, grant_idx, timeout_flag.
- FSM states: IDLE, ACCEPT, BUSY, RESP.
- IDLE:
  - If any req_valid is high, choose the first set bit searching from last_grant+1 upward, wrapping modulo NUM_PORTS.
  - Register g, addr, wdata and we from that port; go to ACCEPT.
  - If no request, stay in IDLE.
- ACCEPT (1 cycle):
  - req_ready[g]=1; grant_idx=g.
  - The client must drop or advance req_valid the next cycle.
  - Go to BUSY.
- BUSY:
  - mem_read=!we and mem_write=we, held as levels.
  - mem_addr and mem_wdata are driven from the latched registers, stable for the whole state.
  - On mem_done=1: drop the strobe the next cycle, latch mem_rdata (reads only; writes latch 0), go to RESP.
- RESP (1 cycle):
  - rsp_valid[g]=1, rsp_rdata=latched value, rsp_err as applicable.
  - last_grant=g; go to IDLE.
- Latency: accept→rsp_valid = (cycles in BUSY) + 1. Minimum request→response is 4 cycles when mem_done arrives on the first BUSY cycle.
- Throughput: at most one access per (BUSY length + 3) cycles. No back-to-back issue: IDLE is always visited.
- Fairness: a continuously requesting port is served within NUM_PORTS grants.
- Request changes after acceptance: ignored, because all request fields are latched in IDLE.
- A port that drops req_valid before it is granted is simply not selected. There is no penalty.
- mem_done while not in BUSY is ignored.
- Reset mid-access returns to IDLE immediately and drops the strobe. The SRAM controller is reset by the same rst.
- Widths: grant index is 3 bits, which covers NUM_PORTS ≤ 8. Wrap is a compare against NUM_PORTS-1, not a power-of-two mask.

Optional Feature:
- Macro: SRAM_ARB_TIMEOUT_EN.
- With it defined:
  - A cycle counter (11 bits) clears on entry to BUSY.
  - When the counter reaches TIMEOUT_CYC without mem_done, the FSM drops the strobe, goes to RESP with rsp_err=1 and rsp_rdata=0, and sets timeout_flag (sticky until reset).
- Without it: BUSY waits indefinitely; rsp_err and timeout_flag are tied to 0; no counter logic is instantiated.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_IDLE=0, ST_ACCEPT=1, ST_BUSY=2, ST_RESP=3).
  - Default ADDR_W/DATA_W constants shared with ram_ctrl.
- One sub-module, rr_pick: combinational round-robin priority encoder (req vector, last_grant → grant index, any).
- Everything else stays in sram_arbiter.

Test Plan:
- Single read on port 2, addr 0x00ABC, mem_done after 3 BUSY cycles with mem_rdata=0xDEADBEEF → req_ready[2] pulse, mem_read high 3 cycles, rsp_valid[2] with rsp_rdata=0xDEADBEEF 6 cycles after req_valid.
- All 4 ports request continuously, mem_done=1 on the first BUSY cycle → grants in order 0,1,2,3,0,… and rsp_valid pulses every 4 cycles.
- Port 1 write 0x12345678 to 0xFFFFF while port 3 reads → port 1 served first, mem_wdata/mem_addr stable through BUSY, then port 3; write response has rsp_rdata=0.
- Assert rst low during BUSY → next cycle mem_read=mem_write=0, busy=0; after release, port 0 wins the first grant.
- Spurious mem_done in IDLE, and req_addr changed after ACCEPT → no state change; mem_addr keeps the latched value.
- With SRAM_ARB_TIMEOUT_EN defined and mem_done never asserted → abort after 1023 BUSY cycles, rsp_err=1, rsp_rdata=0, timeout_flag stays 1; the next request completes normally.
